// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor for the EX-stage ALU.
// Processes WIDTH bits as WIDTH/CHUNK slices, one per clock, carry held between.
module addsub_seq #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             zf,
   output logic             sf,
   output logic             of
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int M  = WIDTH - 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [CHUNK:0]   slice_sum;
   logic             last;
   int               base;

   assign last = (idx == LAST);
   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   // next-state logic: accept in IDLE, run N slices, one DONE cycle
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:  if (start) state_next = S_RUN;
         S_RUN:   if (last) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // one slice of the addition, merged into the accumulator image
   always_comb begin
      base      = int'(idx) * CHUNK;
      slice_sum = {1'b0, a_q[base +: CHUNK]}
                + {1'b0, b_q[base +: CHUNK]}
                + {{CHUNK{1'b0}}, carry};
      acc_next  = acc;
      acc_next[base +: CHUNK] = slice_sum[CHUNK-1:0];
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // operand latch, slice index, carry chain and accumulator
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         acc   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_q   <= a;
                  b_q   <= sub ? ~b : b;
                  carry <= sub;
                  idx   <= '0;
               end
            end
            S_RUN: begin
               acc   <= acc_next;
               carry <= slice_sum[CHUNK];
               idx   <= idx + IW'(1);
            end
            default: ;
         endcase
      end
   end

   // result and flags load only on the edge entering DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
         c_out  <= 1'b0;
         zf     <= 1'b0;
         sf     <= 1'b0;
         of     <= 1'b0;
      end else if (state == S_RUN && last) begin
         result <= acc_next;
         c_out  <= slice_sum[CHUNK];
         zf     <= (acc_next == '0);
         sf     <= acc_next[M];
         // b_q holds ~b for sub, so one rule covers add and sub
         of     <= (a_q[M] == b_q[M]) && (acc_next[M] != a_q[M]);
      end
   end

endmodule

// File: tb/tb_addsub_seq.sv
// Directed self-checking bench for addsub_seq.
// u0 runs 64/16 (4 slices); u1 runs 64/64 (1 slice).
module tb_addsub_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start0;
   logic        start1;
   logic        sub;
   logic [63:0] a;
   logic [63:0] b;

   logic        busy0, done0, c_out0, zf0, sf0, of0;
   logic [63:0] result0;
   logic        busy1, done1, c_out1, zf1, sf1, of1;
   logic [63:0] result1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   addsub_seq #(.WIDTH(64), .CHUNK(16)) u0 (
      .clk(clk), .rst(rst), .start(start0), .sub(sub), .a(a), .b(b),
      .busy(busy0), .done(done0), .result(result0), .c_out(c_out0),
      .zf(zf0), .sf(sf0), .of(of0)
   );

   addsub_seq #(.WIDTH(64), .CHUNK(64)) u1 (
      .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b),
      .busy(busy1), .done(done1), .result(result1), .c_out(c_out1),
      .zf(zf1), .sf(sf1), .of(of1)
   );

   // Issue one op; returns at the negedge where done is seen (or bound hit).
   // lat counts edges from acceptance (inclusive) to the done cycle.
   task automatic do_op(input logic sel, input logic [63:0] av,
                        input logic [63:0] bv, input logic sv,
                        output int lat, output int bcnt);
      @(negedge clk);
      a = av; b = bv; sub = sv;
      if (sel) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      lat = 1; bcnt = 0;
      forever begin
         if (sel ? busy1 : busy0) bcnt++;
         if (sel ? done1 : done0) break;
         if (lat >= 40) break;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
      sub = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy0); end
      tests++; if (done0 !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done0); end
      tests++; if (result0 !== 64'd0) begin fails++; $display("FAIL reset_result got %h want 0", result0); end
      tests++; if ({c_out0, zf0, sf0, of0} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b want 0000", {c_out0, zf0, sf0, of0}); end
      rst = 1'b0;
      @(negedge clk);
      tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_idle got %b want 0", busy0); end
   endtask

   task automatic test_add;
      int lat, bc;
      do_op(1'b0, 64'd1, 64'd2, 1'b0, lat, bc);
      tests++; if (lat != 5) begin fails++; $display("FAIL add_latency got %0d want 5", lat); end
      tests++; if (bc != 5) begin fails++; $display("FAIL add_busy_cycles got %0d want 5", bc); end
      tests++; if (result0 !== 64'd3) begin fails++; $display("FAIL add_result got %h want 3", result0); end
      tests++; if ({c_out0, zf0, sf0, of0} !== 4'b0000) begin fails++; $display("FAIL add_flags got %b want 0000", {c_out0, zf0, sf0, of0}); end
      @(negedge clk);
      tests++; if ({busy0, done0} !== 2'b00) begin fails++; $display("FAIL add_after_done got %b want 00", {busy0, done0}); end
      tests++; if (result0 !== 64'd3) begin fails++; $display("FAIL add_hold got %h want 3", result0); end
   endtask

   task automatic test_sub_chain;
      int lat, bc;
      do_op(1'b0, 64'h0000_0001_0000_0000, 64'd1, 1'b1, lat, bc);
      tests++; if (result0 !== 64'h0000_0000_FFFF_FFFF) begin fails++; $display("FAIL subchain_result got %h want 00000000ffffffff", result0); end
      tests++; if ({c_out0, zf0, sf0, of0} !== 4'b1000) begin fails++; $display("FAIL subchain_flags got %b want 1000", {c_out0, zf0, sf0, of0}); end
   endtask

   task automatic test_overflow;
      int lat, bc;
      do_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat, bc);
      tests++; if (result0 !== 64'h8000_0000_0000_0000) begin fails++; $display("FAIL ovf_result got %h want 8000000000000000", result0); end
      tests++; if ({c_out0, zf0, sf0, of0} !== 4'b0011) begin fails++; $display("FAIL ovf_flags got %b want 0011", {c_out0, zf0, sf0, of0}); end
   endtask

   task automatic test_borrow_equal;
      int lat, bc;
      do_op(1'b0, 64'd0, 64'd1, 1'b1, lat, bc);
      tests++; if (result0 !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL borrow_result got %h want ffffffffffffffff", result0); end
      tests++; if ({c_out0, zf0, sf0, of0} !== 4'b0010) begin fails++; $display("FAIL borrow_flags got %b want 0010", {c_out0, zf0, sf0, of0}); end
      do_op(1'b0, 64'd5, 64'd5, 1'b1, lat, bc);
      tests++; if (result0 !== 64'd0) begin fails++; $display("FAIL equal_result got %h want 0", result0); end
      tests++; if ({c_out0, zf0, sf0, of0} !== 4'b1100) begin fails++; $display("FAIL equal_flags got %b want 1100", {c_out0, zf0, sf0, of0}); end
   endtask

   task automatic test_wrap;
      int lat, bc;
      do_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat, bc);
      tests++; if (result0 !== 64'd0) begin fails++; $display("FAIL wrap_result got %h want 0", result0); end
      tests++; if ({c_out0, zf0, sf0, of0} !== 4'b1100) begin fails++; $display("FAIL wrap_flags got %b want 1100", {c_out0, zf0, sf0, of0}); end
   endtask

   task automatic test_ignore_start;
      int lat;
      @(negedge clk);
      a = 64'd1; b = 64'd2; sub = 1'b0; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; lat = 1;
      @(negedge clk);
      lat = 2;
      a = 64'd100; b = 64'd200; sub = 1'b1; start0 = 1'b1;
      @(negedge clk);
      lat = 3; start0 = 1'b0;
      while (!done0 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      tests++; if (lat != 5) begin fails++; $display("FAIL ignore_latency got %0d want 5", lat); end
      tests++; if (result0 !== 64'd3) begin fails++; $display("FAIL ignore_result got %h want 3", result0); end
      tests++; if ({c_out0, of0} !== 2'b00) begin fails++; $display("FAIL ignore_flags got %b want 00", {c_out0, of0}); end
      repeat (2) begin
         @(negedge clk);
         tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL ignore_not_queued got %b want 0", busy0); end
      end
   endtask

   task automatic test_abort;
      int seen;
      @(negedge clk);
      a = 64'h1234; b = 64'd1; sub = 1'b0; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++; if ({busy0, done0} !== 2'b00) begin fails++; $display("FAIL abort_ctrl got %b want 00", {busy0, done0}); end
      tests++; if (result0 !== 64'd0) begin fails++; $display("FAIL abort_result got %h want 0", result0); end
      tests++; if ({c_out0, zf0, sf0, of0} !== 4'b0000) begin fails++; $display("FAIL abort_flags got %b want 0000", {c_out0, zf0, sf0, of0}); end
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done0 || busy0) seen++;
      end
      tests++; if (seen != 0) begin fails++; $display("FAIL abort_no_done got %0d active cycles want 0", seen); end
   endtask

   task automatic test_single_chunk;
      int lat, bc;
      do_op(1'b1, 64'd3, 64'd7, 1'b1, lat, bc);
      tests++; if (lat != 2) begin fails++; $display("FAIL n1_latency got %0d want 2", lat); end
      tests++; if (bc != 2) begin fails++; $display("FAIL n1_busy_cycles got %0d want 2", bc); end
      tests++; if (result1 !== 64'hFFFF_FFFF_FFFF_FFFC) begin fails++; $display("FAIL n1_result got %h want fffffffffffffffc", result1); end
      tests++; if ({c_out1, zf1, sf1, of1} !== 4'b0010) begin fails++; $display("FAIL n1_flags got %b want 0010", {c_out1, zf1, sf1, of1}); end
   endtask

   task automatic test_back_to_back;
      int lat;
      @(negedge clk);
      a = 64'd5; b = 64'd3; sub = 1'b1; start0 = 1'b1;
      lat = 0;
      @(negedge clk);
      while (!done0 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      tests++; if (result0 !== 64'd2) begin fails++; $display("FAIL b2b_first got %h want 2", result0); end
      @(negedge clk);
      tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap got %b want 0", busy0); end
      @(negedge clk);
      tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL b2b_reaccept got %b want 1", busy0); end
      start0 = 1'b0;
      a = 64'd9; b = 64'd9; sub = 1'b0;
      lat = 1;
      while (!done0 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      tests++; if (lat != 5) begin fails++; $display("FAIL b2b_latency got %0d want 5", lat); end
      tests++; if (result0 !== 64'd2) begin fails++; $display("FAIL b2b_second got %h want 2", result0); end
   endtask

   initial begin
      test_reset;
      test_add;
      test_sub_chain;
      test_overflow;
      test_borrow_equal;
      test_wrap;
      test_ignore_start;
      test_abort;
      test_single_chunk;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
